// File: rtl/mac_pkg.sv
// Shared state encoding and width constants for the MAC dot-product sequencer.
package mac_pkg;

  localparam int unsigned ACC_WIDTH_C  = 40;
  localparam int unsigned DATA_WIDTH_C = 16;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ISSUE,
    WAIT,
    SETTLE,
    DONE
  } seq_state_t;

endpackage

// File: rtl/mac_watchdog.sv
// Cycle counter for the WAIT state: restarts on clr, counts while en,
// flags expired on the LIMIT-th enabled cycle.
module mac_watchdog #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = en && (count == CW'(LIMIT - 1));

endmodule

// File: rtl/mac_dot_sequencer.sv
// Sequences the MAC through an N-element dot product and returns the sum.
// Defining MAC_TIMEOUT_EN adds a watchdog that aborts a stalled WAIT with res_error.
module mac_dot_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DATA_WIDTH_C,
  parameter int unsigned ACC_WIDTH      = ACC_WIDTH_C,
  parameter int unsigned MAX_LEN        = 256,
  parameter int unsigned LEN_WIDTH      = $clog2(MAX_LEN + 1),
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  abort,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_m,
  input  logic [DATA_WIDTH-1:0] op_q,
  output logic                  mac_start,
  output logic                  mac_clr_acc,
  output logic [DATA_WIDTH-1:0] mac_m,
  output logic [DATA_WIDTH-1:0] mac_q,
  input  logic                  mac_ready,
  input  logic [ACC_WIDTH-1:0]  mac_product,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [ACC_WIDTH-1:0]  res_data,
  output logic                  res_error,
  output logic                  busy
);

  localparam logic [LEN_WIDTH-1:0] MAX_LEN_L = LEN_WIDTH'(MAX_LEN);
  localparam logic [LEN_WIDTH-1:0] ONE_L     = LEN_WIDTH'(1);

  seq_state_t           state_q, state_d;
  logic [LEN_WIDTH-1:0] remaining;
  logic                 cmd_fire, op_fire, ready_fire, abort_hit, timeout_hit;

  assign cmd_ready = (state_q == IDLE);
  assign op_ready  = (state_q == ISSUE);
  assign busy      = (state_q != IDLE);

  assign abort_hit  = abort && (state_q inside {CLEAR, ISSUE, WAIT, SETTLE});
  assign cmd_fire   = cmd_ready && cmd_valid;
  assign op_fire    = op_ready && op_valid && !abort_hit;
  assign ready_fire = (state_q == WAIT) && mac_ready && !abort_hit;

`ifdef MAC_TIMEOUT_EN
  logic wd_expired;

  mac_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_d == WAIT && state_q != WAIT),
    .en      (state_q == WAIT),
    .expired (wd_expired)
  );

  // A product arriving on the expiry cycle still counts.
  assign timeout_hit = wd_expired && !mac_ready && !abort_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_error <= 1'b0;
    end else if (timeout_hit) begin
      res_error <= 1'b1;
    end else if (state_q == DONE && res_ready) begin
      res_error <= 1'b0;
    end
  end
`else
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end

  assign timeout_hit = 1'b0;
  assign res_error   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = CLEAR;
      CLEAR:   state_d = (remaining != '0) ? ISSUE : SETTLE;
      ISSUE:   if (op_valid) state_d = WAIT;
      WAIT: begin
        if (mac_ready) state_d = (remaining <= ONE_L) ? SETTLE : ISSUE;
        else if (timeout_hit) state_d = DONE;
      end
      SETTLE:  state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining   <= '0;
      mac_start   <= 1'b0;
      mac_clr_acc <= 1'b0;
      mac_m       <= '0;
      mac_q       <= '0;
      res_valid   <= 1'b0;
      res_data    <= '0;
    end else begin
      state_q     <= state_d;
      mac_start   <= op_fire;
      mac_clr_acc <= cmd_fire || abort_hit || timeout_hit;
      res_valid   <= (state_d == DONE);

      if (cmd_fire) begin
        remaining <= (cmd_len > MAX_LEN_L) ? MAX_LEN_L : cmd_len;
      end else if (ready_fire && remaining != '0) begin
        remaining <= remaining - ONE_L;
      end

      if (op_fire) begin
        mac_m <= op_m;
        mac_q <= op_q;
      end

      // The accumulator has absorbed the last product by the SETTLE cycle.
      if (state_q == SETTLE && !abort_hit) begin
        res_data <= mac_product;
      end else if (timeout_hit) begin
        res_data <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Directed bench for mac_dot_sequencer with a small behavioural MAC
// (fixed latency, 40-bit accumulator enabled by mac_ready).
module tb_mac_dot_sequencer;
  import mac_pkg::*;

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = 40;
  localparam int unsigned LW  = 9;
  localparam int unsigned LIM = 400;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0, cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic          abort = 1'b0;
  logic          op_valid = 1'b0, op_ready;
  logic [DW-1:0] op_m = '0, op_q = '0;
  logic          mac_start, mac_clr_acc;
  logic [DW-1:0] mac_m, mac_q;
  logic          mac_ready;
  logic [AW-1:0] mac_product;
  logic          res_valid, res_ready = 1'b0, res_error, busy;
  logic [AW-1:0] res_data;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned start_cnt = 0;
  int unsigned clr_cnt = 0;
  logic        mac_mute = 1'b0;

  always #5 clk = ~clk;

  mac_dot_sequencer #(
    .DATA_WIDTH     (DW),
    .ACC_WIDTH      (AW),
    .MAX_LEN        (256),
    .LEN_WIDTH      (LW),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_len     (cmd_len),
    .abort       (abort),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_m        (op_m),
    .op_q        (op_q),
    .mac_start   (mac_start),
    .mac_clr_acc (mac_clr_acc),
    .mac_m       (mac_m),
    .mac_q       (mac_q),
    .mac_ready   (mac_ready),
    .mac_product (mac_product),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_error   (res_error),
    .busy        (busy)
  );

  // Behavioural MAC: product ready two cycles after start, accumulate on mac_ready.
  logic signed [AW-1:0] prod, acc;
  logic [1:0]           lat;
  assign mac_product = acc;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lat <= '0; mac_ready <= 1'b0; acc <= '0; prod <= '0;
    end else begin
      mac_ready <= 1'b0;
      if (mac_clr_acc) acc <= '0;
      else if (mac_ready) acc <= acc + prod;
      if (mac_start) begin
        prod <= $signed(mac_m) * $signed(mac_q);
        lat  <= 2'd2;
      end else if (lat != 2'd0) begin
        lat <= lat - 2'd1;
        if (lat == 2'd1 && !mac_mute) mac_ready <= 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst && mac_start) start_cnt <= start_cnt + 1;
    if (!rst && mac_clr_acc) clr_cnt <= clr_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [LW-1:0] len);
    int unsigned n = 0;
    cmd_len = len; cmd_valid = 1'b1;
    while (!cmd_ready && n < LIM) begin @(negedge clk); n++; end
    chk("cmd_hs_bound", 64'(n < LIM), 64'd1);
    @(negedge clk); cmd_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [DW-1:0] m, input logic [DW-1:0] q);
    int unsigned n = 0;
    op_m = m; op_q = q; op_valid = 1'b1;
    while (!op_ready && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("op_hs_bound", 64'(n), 64'(LIM - 1));
    @(negedge clk); op_valid = 1'b0;
  endtask

  task automatic wait_op_ready();
    int unsigned n = 0;
    while (!op_ready && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) chk("op_ready_bound", 64'(op_ready), 64'd1);
  endtask

  task automatic wait_res();
    int unsigned n = 0;
    while (!res_valid && n < LIM) begin @(negedge clk); n++; end
    chk("res_valid_bound", 64'(res_valid), 64'd1);
  endtask

  task automatic take_res();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout observed hang expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int unsigned s0, c0;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_mac_start", 64'(mac_start), 64'd0);
    chk("rst_res_data", 64'(res_data), 64'd0);
    chk("rst_res_error", 64'(res_error), 64'd0);

    // Basic: (3*4) + (-2*5) + (7*-1) = -5
    s0 = start_cnt;
    send_cmd(9'd3);
    chk("basic_clear", 64'(mac_clr_acc), 64'd1);
    send_pair(16'd3, 16'd4);
    send_pair(-16'sd2, 16'd5);
    send_pair(16'd7, -16'sd1);
    wait_res();
    chk("basic_data", 64'(res_data), 64'h00FF_FFFF_FFFB);
    repeat (3) @(negedge clk);
    chk("basic_hold_valid", 64'(res_valid), 64'd1);
    chk("basic_starts", 64'(start_cnt - s0), 64'd3);
    take_res();
    chk("basic_valid_drop", 64'(res_valid), 64'd0);
    chk("basic_idle", 64'(cmd_ready), 64'd1);

    // Zero length: result 3 cycles after the command handshake
    s0 = start_cnt; c0 = clr_cnt;
    send_cmd(9'd0);
    chk("zero_clr", 64'(mac_clr_acc), 64'd1);
    chk("zero_v1", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("zero_v2", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("zero_v3", 64'(res_valid), 64'd1);
    chk("zero_data", 64'(res_data), 64'd0);
    chk("zero_starts", 64'(start_cnt - s0), 64'd0);
    chk("zero_clr_cnt", 64'(clr_cnt - c0), 64'd1);
    take_res();

    // Backpressure: (100*-3) + (-50*-4) = -100
    send_cmd(9'd2);
    send_pair(16'd100, -16'sd3);
    wait_op_ready();
    s0 = start_cnt;
    repeat (5) @(negedge clk);
    chk("gap_no_start", 64'(start_cnt - s0), 64'd0);
    send_pair(-16'sd50, -16'sd4);
    wait_res();
    repeat (10) @(negedge clk);
    chk("bp_data", 64'(res_data), 64'h00FF_FFFF_FF9C);
    chk("bp_valid", 64'(res_valid), 64'd1);
    chk("bp_cmd_ready", 64'(cmd_ready), 64'd0);
    take_res();
    chk("bp_done", 64'(cmd_ready), 64'd1);

    // Abort after the second product
    send_cmd(9'd4);
    send_pair(16'd1, 16'd1);
    send_pair(16'd2, 16'd2);
    wait_op_ready();
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_clr", 64'(mac_clr_acc), 64'd1);
    repeat (4) @(negedge clk);
    chk("abort_no_res", 64'(res_valid), 64'd0);

    // Asynchronous reset mid-WAIT
    send_cmd(9'd2);
    send_pair(16'd5, 16'd5);
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_start", 64'(mac_start), 64'd0);
    chk("arst_mac_m", 64'(mac_m), 64'd0);
    chk("arst_cmd_ready", 64'(cmd_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("arst_no_res", 64'(res_valid), 64'd0);

    // Saturation: 300 -> 256 pairs of (i * -1), sum = -32640
    s0 = start_cnt;
    send_cmd(9'd300);
    for (int i = 0; i < 256; i++) send_pair(16'(i), -16'sd1);
    wait_res();
    chk("sat_starts", 64'(start_cnt - s0), 64'd256);
    chk("sat_data", 64'(res_data), 64'h00FF_FFFF_8080);
    take_res();

    // Back-to-back: CLEAR immediately after the previous handshake
    send_cmd(9'd2);
    chk("b2b_clear", 64'(mac_clr_acc), 64'd1);
    send_pair(16'd32767, 16'd32767);
    send_pair(16'd32767, 16'd32767);
    wait_res();
    chk("b2b_data", 64'(res_data), 64'd2147352578);
    take_res();

`ifdef MAC_TIMEOUT_EN
    mac_mute = 1'b1;
    send_cmd(9'd1);
    send_pair(16'd9, 16'd9);
    repeat (63) @(negedge clk);
    chk("to_wait_63", 64'(res_valid), 64'd0);
    @(negedge clk);
    chk("to_valid", 64'(res_valid), 64'd1);
    chk("to_error", 64'(res_error), 64'd1);
    chk("to_data", 64'(res_data), 64'd0);
    take_res();
    chk("to_error_clr", 64'(res_error), 64'd0);
    mac_mute = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
